// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: FSM state
// encoding, Funct3 access-size codes and default geometry/timing.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int DEPTH_DEF       = 128;
  localparam int WAIT_CYCLES_DEF = 2;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte-enables/data replication and
// load lane select with sign/zero extension. TRAP_EN enables misalign flagging.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter bit TRAP_EN = 1'b0
) (
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] rd_word,
  output logic [3:0]  byte_en,
  output logic [31:0] st_word,
  output logic [31:0] ld_data,
  output logic        misalign
);

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
    logic signed [7:0]  bs;
    logic signed [31:0] wide;
    bs   = b;
    wide = bs;
    if (sgn) return wide;
    return {24'h0, b};
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
    logic signed [15:0] hs;
    logic signed [31:0] wide;
    hs   = h;
    wide = hs;
    if (sgn) return wide;
    return {16'h0, h};
  endfunction

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign sel_byte = rd_word[{addr_lo, 3'b000} +: 8];
  assign sel_half = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];

  // Reserved codes fall through to the word case; lane selection only uses
  // the address bits that matter, which implicitly aligns H and W accesses.
  always_comb begin
    byte_en  = 4'b1111;
    st_word  = st_data;
    ld_data  = rd_word;
    misalign = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        byte_en = 4'b0001 << addr_lo;
        st_word = {4{st_data[7:0]}};
        ld_data = ext_byte(sel_byte, funct3 == F3_B);
      end
      F3_H, F3_HU: begin
        byte_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
        st_word  = {2{st_data[15:0]}};
        ld_data  = ext_half(sel_half, funct3 == F3_H);
        misalign = TRAP_EN && addr_lo[0];
      end
      default: begin
        misalign = TRAP_EN && (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with IDLE/WAIT/RESP handshake.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (flag and suppress misaligned H/W accesses).
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] WrData,
  output logic [31:0] RdData,
  output logic        Stall,
  output logic        Done,
  output logic        MisalignErr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_t state, state_nxt;
  logic [3:0] wcnt;
  logic       req;
  logic       go_resp;

  logic [AW+1:0] addr_p0;
  logic [2:0]    f3_p0;
  logic [31:0]   wdata_p0;
  logic          store_p0;

  logic [AW+1:0] cur_addr;
  logic [2:0]    cur_f3;
  logic [31:0]   cur_wdata;
  logic          cur_store;
  logic [AW-1:0] cur_idx;

  logic [3:0]  byte_en;
  logic [31:0] st_word;
  logic [31:0] ld_data;
  logic        mis;
  logic        unused_addr;

  logic [31:0] mem [DEPTH];

  assign req         = MemRead | MemWrite;
  assign unused_addr = ^Addr[31:AW+2];

  // In IDLE the live request drives the datapath so a zero-wait store can
  // commit on its acceptance edge; afterwards the latched copy is used.
  assign cur_addr  = (state == IDLE) ? Addr[AW+1:0] : addr_p0;
  assign cur_f3    = (state == IDLE) ? Funct3       : f3_p0;
  assign cur_wdata = (state == IDLE) ? WrData       : wdata_p0;
  assign cur_store = (state == IDLE) ? MemWrite     : store_p0;
  assign cur_idx   = cur_addr[AW+1:2];

  dmem_lane_align #(
    .TRAP_EN (TRAP_EN)
  ) u_lane (
    .funct3   (cur_f3),
    .addr_lo  (cur_addr[1:0]),
    .st_data  (cur_wdata),
    .rd_word  (mem[cur_idx]),
    .byte_en  (byte_en),
    .st_word  (st_word),
    .ld_data  (ld_data),
    .misalign (mis)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req) state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: if (wcnt == WAIT_LAST) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign go_resp = (state_nxt == RESP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= (state == WAIT) ? wcnt + 4'd1 : 4'd0;
    end
  end

  // Request capture (p0)
  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      addr_p0  <= Addr[AW+1:0];
      f3_p0    <= Funct3;
      wdata_p0 <= WrData;
      store_p0 <= MemWrite;
    end
  end

  // Store commit on the edge entering RESP; reset aborts it.
  always_ff @(posedge clk) begin
    if (!reset && go_resp && cur_store && !mis) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[cur_idx][8*i +: 8] <= st_word[8*i +: 8];
      end
    end
  end

  assign Stall  = (state == IDLE && req) || (state == WAIT);
  assign Done   = (state == RESP);
  assign RdData = (state == RESP && !store_p0 && !mis) ? ld_data : 32'h0;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign MisalignErr = (state == RESP) && mis;
`else
  assign MisalignErr = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, reset/abort sequences and
// randomized accesses checked against a byte-array memory model.
module tb_dmem_responder;

  localparam int DEPTH       = 128;
  localparam int WAIT_CYCLES = 2;
  localparam int NBYTES      = DEPTH * 4;

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [2:0]  Funct3 = 3'b000;
  logic [31:0] Addr = 32'h0;
  logic [31:0] WrData = 32'h0;
  logic [31:0] RdData;
  logic        Stall;
  logic        Done;
  logic        MisalignErr;

  int checks = 0;
  int failures = 0;

  byte unsigned mm [NBYTES];

  typedef struct {
    bit          rd;
    bit          wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [14];

  dmem_responder #(
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .Funct3      (Funct3),
    .Addr        (Addr),
    .WrData      (WrData),
    .RdData      (RdData),
    .Stall       (Stall),
    .Done        (Done),
    .MisalignErr (MisalignErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: memory as a flat byte array, accesses by size/alignment arithmetic.
  task automatic model(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] er, output logic em);
    int sz, off, base;
    bit sgn;
    longint v;
    sz  = (f3 == 3'b000 || f3 == 3'b100) ? 1 : (f3 == 3'b001 || f3 == 3'b101) ? 2 : 4;
    sgn = (f3 == 3'b000 || f3 == 3'b001);
    off = int'(a % NBYTES);
    base = off - (off % sz);
    em = TRAP && (off % sz) != 0;
    er = 32'h0;
    if (wr) begin
      if (!em) for (int k = 0; k < sz; k++) mm[base + k] = wd[8*k +: 8];
    end else if (!em) begin
      v = 0;
      for (int k = 0; k < sz; k++) v = v + (longint'(mm[base + k]) << (8 * k));
      if (sgn && sz < 4 && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
      er = 32'(v);
    end
  endtask

  // Called at a falling edge with the DUT idle; returns at the falling edge of
  // the IDLE cycle that follows Done, ready for a back-to-back request.
  task automatic do_access(input string tag, input bit rd, input bit wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rdv, output logic misv);
    int n, st;
    bit got;
    MemRead = rd; MemWrite = wr; Funct3 = f3; Addr = a; WrData = wd;
    #1 chk({tag, ":stall_accept"}, 32'(Stall), 32'd1);
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
    n = 0; st = 0; got = 1'b0; rdv = 32'h0; misv = 1'b0;
    while (!got && n < 50) begin
      @(negedge clk);
      n++;
      if (Done) begin
        got  = 1'b1;
        rdv  = RdData;
        misv = MisalignErr;
        chk({tag, ":stall_at_done"}, 32'(Stall), 32'd0);
      end else if (Stall) st++;
    end
    chk({tag, ":done_seen"}, 32'(got), 32'd1);
    chk({tag, ":latency"}, 32'(n), 32'(WAIT_CYCLES + 1));
    chk({tag, ":stall_wait"}, 32'(st), 32'(WAIT_CYCLES));
    @(negedge clk);
    chk({tag, ":done_pulse"}, 32'(Done), 32'd0);
  endtask

  task automatic run(input string tag, input bit rd, input bit wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] er, rv;
    logic em, mv;
    model(wr, f3, a, wd, er, em);
    do_access(tag, rd, wr, f3, a, wd, rv, mv);
    chk({tag, ":rdata"}, rv, er);
    chk({tag, ":misalign"}, 32'(mv), 32'(em));
  endtask

  initial begin
    logic [31:0] er, rv;
    logic em, mv;
    bit rr, ww;

    tbl[0]  = '{1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE};
    tbl[3]  = '{1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE};
    tbl[4]  = '{1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD};
    tbl[5]  = '{1'b1, 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF};
    tbl[6]  = '{1'b0, 1'b1, 3'b000, 32'h11, 32'h000000AA, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADAAEF};
    tbl[8]  = '{1'b1, 1'b1, 3'b010, 32'h30, 32'h5, 32'h0};
    tbl[9]  = '{1'b1, 1'b0, 3'b010, 32'h30, 32'h0, 32'h5};
    tbl[10] = '{1'b1, 1'b0, 3'b010, 32'(NBYTES + 32'h30), 32'h0, 32'h5};
    tbl[11] = '{1'b0, 1'b1, 3'b010, 32'(NBYTES + 32'h40), 32'hCAFEF00D, 32'h0};
    tbl[12] = '{1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'hCAFEF00D};
    tbl[13] = '{1'b1, 1'b0, 3'b011, 32'h10, 32'h0, 32'hDEADAAEF};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst:stall", 32'(Stall), 32'd0);
    chk("rst:done", 32'(Done), 32'd0);
    chk("rst:rdata", RdData, 32'h0);
    chk("rst:misalign", 32'(MisalignErr), 32'd0);
    reset = 1'b0;

    for (int w = 0; w < DEPTH; w++) run("fill", 1'b0, 1'b1, 3'b010, 32'(w * 4), $urandom);

    for (int i = 0; i < 14; i++) begin
      model(tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wdata, er, em);
      do_access("vec", tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wdata, rv, mv);
      chk($sformatf("vec%0d:rdata", i), rv, tbl[i].exp_rd);
      chk($sformatf("vec%0d:misalign", i), 32'(mv), 32'd0);
    end

    // Reset during the second WAIT cycle aborts the store
    run("pre_abort", 1'b0, 1'b1, 3'b010, 32'h20, 32'h11112222);
    MemWrite = 1'b1; Funct3 = 3'b010; Addr = 32'h20; WrData = 32'h12345678;
    @(posedge clk); #1;
    MemWrite = 1'b0;
    @(negedge clk);
    chk("abort:wait1_stall", 32'(Stall), 32'd1);
    @(negedge clk);
    chk("abort:wait2_stall", 32'(Stall), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort:stall", 32'(Stall), 32'd0);
    chk("abort:done", 32'(Done), 32'd0);
    chk("abort:rdata", RdData, 32'h0);
    chk("abort:misalign", 32'(MisalignErr), 32'd0);
    reset = 1'b0;
    run("abort_readback", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);

    // Misaligned word store and half load
    run("mis_sw", 1'b0, 1'b1, 3'b010, 32'h22, 32'hA5A5A5A5);
    run("mis_readback", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
    run("mis_lh", 1'b1, 1'b0, 3'b001, 32'h21, 32'h0);

    // Reset wins over a simultaneous request
    reset = 1'b1; MemWrite = 1'b1; Funct3 = 3'b010; Addr = 32'h50; WrData = 32'h77;
    @(posedge clk); #1;
    MemWrite = 1'b0;
    @(negedge clk);
    chk("rstprio:stall", 32'(Stall), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rstprio:done", 32'(Done), 32'd0);
    run("rstprio_readback", 1'b1, 1'b0, 3'b010, 32'h50, 32'h0);

    for (int i = 0; i < 300; i++) begin
      ww = $urandom_range(0, 1) != 0;
      rr = !ww || ($urandom_range(0, 3) == 0);
      run("rand", rr, ww, 3'($urandom_range(0, 7)), $urandom, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
